// File: rtl/csm_pkg.sv
// Shared types for the N-port clocked shared memory: access status codes and per-port FSM states.
package csm_pkg;

  typedef enum logic [1:0] {
    ERR_OK        = 2'b00,
    ERR_ADDR      = 2'b01,
    ERR_LOCKED    = 2'b10,
    ERR_LOCKPROTO = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_WDATA,
    P_DONE
  } port_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the pointer; owns the pointer.
module csm_rr_arbiter
  import csm_pkg::*;
#(
  parameter int unsigned N_PORTS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic               block,
  output logic [N_PORTS-1:0] grant
);

  localparam int unsigned PTR_W = idx_w(N_PORTS);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N_PORTS; off++) begin
      idx = PTR_W'((32'(ptr_q) + off) % N_PORTS);
      if (!found && !block && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = PTR_W'((32'(idx) + 1) % N_PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/csm_nport.sv
// N-port shared register file with per-register hold/release locks and round-robin access.
// Define CSM_LOCK_TIMEOUT_EN to auto-release locks left unrefreshed for LOCK_TIMEOUT cycles.
module csm_nport
  import csm_pkg::*;
#(
  parameter int unsigned N_PORTS      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_PORTS-1:0][DATA_W-1:0] p_in_AD,
  input  logic [N_PORTS-1:0]             p_rw,
  input  logic [N_PORTS-1:0]             p_enable,
  input  logic [N_PORTS-1:0]             p_hold,
  input  logic [N_PORTS-1:0]             p_release,
  output logic [N_PORTS-1:0]             p_ack,
  output logic [N_PORTS-1:0][1:0]        p_err,
  output logic [N_PORTS-1:0][DATA_W-1:0] p_out_data
);

  localparam int unsigned ADDR_W = idx_w(DEPTH);
  localparam int unsigned PORT_W = idx_w(N_PORTS);

  if (N_PORTS < 2 || LOCK_TIMEOUT < 2) begin : g_bad_param
    $error("csm_nport: N_PORTS and LOCK_TIMEOUT must both be at least 2");
  end

  port_state_e       state_q    [N_PORTS];
  port_state_e       state_d    [N_PORTS];
  err_e              err_q      [N_PORTS];
  logic [ADDR_W-1:0] addr_q     [N_PORTS];
  logic [DATA_W-1:0] out_data_q [N_PORTS];
  logic [DATA_W-1:0] regs_q     [DEPTH];
  logic [PORT_W-1:0] lock_owner_q [DEPTH];
  logic [DEPTH-1:0]  lock_valid_q;
  logic [DEPTH-1:0]  lock_expire;

  logic [N_PORTS-1:0] req, grant;
  logic               block;

  always_comb begin
    req   = '0;
    block = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      req[i] = p_enable[i] && (state_q[i] == P_IDLE);
      if (state_q[i] == P_WDATA) block = 1'b1;
    end
  end

  csm_rr_arbiter #(
    .N_PORTS(N_PORTS)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .block(block),
    .grant(grant)
  );

  // Decode of the single granted request; at most one grant per cycle.
  logic              gnt_any;
  logic [PORT_W-1:0] g_idx;
  logic [DATA_W-1:0] g_ad;
  logic [ADDR_W-1:0] g_addr;
  logic              g_rw, g_hold, g_rel, g_owned, g_locked_other;
  err_e              g_err;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) g_idx = PORT_W'(i);
    end
    gnt_any        = |grant;
    g_ad           = p_in_AD[g_idx];
    g_rw           = p_rw[g_idx];
    g_hold         = p_hold[g_idx];
    g_rel          = p_release[g_idx];
    g_addr         = g_ad[ADDR_W-1:0];
    g_owned        = lock_valid_q[g_addr] && (lock_owner_q[g_addr] == g_idx);
    g_locked_other = lock_valid_q[g_addr] && (lock_owner_q[g_addr] != g_idx);
    if ((g_ad >> ADDR_W) != '0) begin
      g_err = ERR_ADDR;
    end else if (g_hold && g_rel) begin
      g_err = ERR_LOCKPROTO;
    end else if (g_rel && !g_owned) begin
      g_err = ERR_LOCKPROTO;
    end else if (g_locked_other && (g_rw || g_hold)) begin
      g_err = ERR_LOCKED;
    end else begin
      g_err = ERR_OK;
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        P_IDLE: begin
          if (grant[i]) state_d[i] = (p_rw[i] && (g_err == ERR_OK)) ? P_WDATA : P_DONE;
        end
        P_WDATA: state_d[i] = P_DONE;
        P_DONE:  state_d[i] = P_IDLE;
        default: state_d[i] = P_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      p_ack[i]      = (state_q[i] == P_DONE);
      p_err[i]      = p_ack[i] ? err_q[i] : ERR_OK;
      p_out_data[i] = out_data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        state_q[i]    <= P_IDLE;
        err_q[i]      <= ERR_OK;
        addr_q[i]     <= '0;
        out_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        state_q[i] <= state_d[i];
        if (grant[i]) begin
          err_q[i]  <= g_err;
          addr_q[i] <= g_addr;
          if (!g_rw && (g_err == ERR_OK)) out_data_q[i] <= regs_q[g_addr];
        end
      end
    end
  end

  // Write data arrives on the bus in the cycle after the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (state_q[i] == P_WDATA) regs_q[addr_q[i]] <= p_in_AD[i];
      end
    end
  end

`ifdef CSM_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = idx_w(LOCK_TIMEOUT);

  logic [CNT_W-1:0] lock_cnt_q [DEPTH];
  logic             lock_touch;

  assign lock_touch = gnt_any && (g_err == ERR_OK) && (g_hold || g_owned);

  always_comb begin
    lock_expire = '0;
    for (int r = 0; r < DEPTH; r++) begin
      lock_expire[r] = lock_valid_q[r] && (lock_cnt_q[r] == CNT_W'(LOCK_TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) lock_cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (lock_valid_q[r]) lock_cnt_q[r] <= lock_cnt_q[r] + 1'b1;
      end
      if (lock_touch) lock_cnt_q[g_addr] <= '0;
    end
  end
`else
  assign lock_expire = '0;
`endif

  // Later assignments win: an owner access in the expiry cycle keeps or releases the lock as asked.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= '0;
      for (int r = 0; r < DEPTH; r++) lock_owner_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (lock_expire[r]) lock_valid_q[r] <= 1'b0;
      end
      if (gnt_any && (g_err == ERR_OK)) begin
        if (g_hold) begin
          lock_valid_q[g_addr] <= 1'b1;
          lock_owner_q[g_addr] <= g_idx;
        end else if (g_rel) begin
          lock_valid_q[g_addr] <= 1'b0;
        end else if (g_owned) begin
          lock_valid_q[g_addr] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csm_nport.sv
// Directed self-checking bench for csm_nport with default parameters (4 ports, 8-bit, depth 8).
module tb_csm_nport;

  localparam int NP = 4;
  localparam int DW = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NP-1:0][DW-1:0]  p_in_AD;
  logic [NP-1:0]          p_rw, p_enable, p_hold, p_release;
  logic [NP-1:0]          p_ack;
  logic [NP-1:0][1:0]     p_err;
  logic [NP-1:0][DW-1:0]  p_out_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csm_nport dut (
    .clk       (clk),
    .reset     (reset),
    .p_in_AD   (p_in_AD),
    .p_rw      (p_rw),
    .p_enable  (p_enable),
    .p_hold    (p_hold),
    .p_release (p_release),
    .p_ack     (p_ack),
    .p_err     (p_err),
    .p_out_data(p_out_data)
  );

  task automatic idle_inputs();
    p_in_AD   = '0;
    p_rw      = '0;
    p_enable  = '0;
    p_hold    = '0;
    p_release = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One isolated access; write data is driven in the cycle after the (immediate) grant.
  task automatic access(input int p, input bit rw, input logic [7:0] ad, input logic [7:0] wd,
                        input bit hold, input bit rel,
                        output logic [1:0] err, output logic [7:0] dout, output int lat);
    p_enable[p]  = 1'b1;
    p_rw[p]      = rw;
    p_in_AD[p]   = ad;
    p_hold[p]    = hold;
    p_release[p] = rel;
    err  = 2'bxx;
    dout = 'x;
    lat  = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (p_ack[p]) begin
        err  = p_err[p];
        dout = p_out_data[p];
        lat  = c;
        break;
      end
      if (c == 1 && rw) p_in_AD[p] = wd;
    end
    p_enable[p]  = 1'b0;
    p_rw[p]      = 1'b0;
    p_in_AD[p]   = '0;
    p_hold[p]    = 1'b0;
    p_release[p] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (p_ack !== 4'h0) begin
      n_fail++; $display("FAIL reset_ack: got %b want 0000", p_ack);
    end
    n_cmp++;
    if (p_err !== 8'h00) begin
      n_fail++; $display("FAIL reset_err: got %h want 00", p_err);
    end
    n_cmp++;
    if (p_out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h want 00000000", p_out_data);
    end
  endtask

  task automatic test_read_after_reset();
    logic [1:0] e; logic [7:0] d; int l;
    access(0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (l !== 1) begin n_fail++; $display("FAIL rd_rst_lat: got %0d want 1", l); end
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL rd_rst_err: got %b want 00", e); end
    n_cmp++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rd_rst_data: got %h want 00", d); end
  endtask

  task automatic test_write_read();
    logic [1:0] e; logic [7:0] d; int l;
    access(1, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (l !== 2) begin n_fail++; $display("FAIL wr_lat: got %0d want 2", l); end
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL wr_err: got %b want 00", e); end
    n_cmp++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL wr_out_hold: got %h want 00", d); end
    access(2, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (l !== 1) begin n_fail++; $display("FAIL rd5_lat: got %0d want 1", l); end
    n_cmp++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL rd5_data: got %h want a5", d); end
  endtask

  task automatic test_contention();
    logic [1:0] e; logic [7:0] d; int l;
    logic [3:0] exp;
    logic [3:0] rot_exp [2];
    do_reset();
    for (int b = 0; b < 2; b++) begin
      p_enable = 4'hF;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        exp = 4'b0001 << k;
        n_cmp++;
        if (p_ack !== exp) begin
          n_fail++; $display("FAIL burst%0d_ack%0d: got %b want %b", b, k, p_ack, exp);
        end
        p_enable = p_enable & ~p_ack;
      end
      p_enable = '0;
      @(posedge clk);
      #1;
    end
    // Pointer ends at 2 after port1 is served, so port3 beats port0.
    access(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, e, d, l);
    rot_exp[0] = 4'b1000;
    rot_exp[1] = 4'b0001;
    p_enable = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (p_ack !== rot_exp[k]) begin
        n_fail++; $display("FAIL rotate_ack%0d: got %b want %b", k, p_ack, rot_exp[k]);
      end
      p_enable = p_enable & ~p_ack;
    end
    p_enable = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lock();
    logic [1:0] e; logic [7:0] d; int l;
    access(0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL lock_hold: got %b want 00", e); end
    access(1, 1'b1, 8'h02, 8'h5A, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b10) begin n_fail++; $display("FAIL lock_wr_other: got %b want 10", e); end
    n_cmp++;
    if (l !== 1) begin n_fail++; $display("FAIL lock_wr_lat: got %0d want 1", l); end
    access(1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL lock_rd_other: got %b want 00", e); end
    n_cmp++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL lock_unchanged: got %h want 00", d); end
    access(1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, e, d, l);
    n_cmp++;
    if (e !== 2'b11) begin n_fail++; $display("FAIL lock_rel_notown: got %b want 11", e); end
    access(0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, e, d, l);
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL lock_rel_own: got %b want 00", e); end
    access(1, 1'b1, 8'h02, 8'h5A, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b00 || l !== 2) begin
      n_fail++; $display("FAIL lock_wr_after: got err %b lat %0d want 00 / 2", e, l);
    end
    access(1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL lock_rd_after: got %h want 5a", d); end
  endtask

  task automatic test_errors();
    logic [1:0] e; logic [7:0] d; int l;
    access(2, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, e, d, l);
    access(2, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b01 || l !== 1) begin
      n_fail++; $display("FAIL bad_addr_rd: got err %b lat %0d want 01 / 1", e, l);
    end
    n_cmp++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL bad_addr_hold_data: got %h want 5a", d); end
    access(2, 1'b1, 8'h80, 8'hFF, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b01 || l !== 1) begin
      n_fail++; $display("FAIL bad_addr_wr: got err %b lat %0d want 01 / 1", e, l);
    end
    access(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL bad_addr_no_wr: got %h want 00", d); end
    access(3, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, e, d, l);
    n_cmp++;
    if (e !== 2'b11) begin n_fail++; $display("FAIL hold_and_rel: got %b want 11", e); end
    n_cmp++;
    if (p_err[3] !== 2'b00 || p_ack !== 4'h0) begin
      n_fail++; $display("FAIL err_after_ack: got err %b ack %b want 00 / 0000", p_err[3], p_ack);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] e; logic [7:0] d; int l;
    access(0, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL mid_pre_hold: got %b want 00", e); end
    p_enable[3] = 1'b1;
    p_rw[3]     = 1'b1;
    p_hold[3]   = 1'b1;
    p_in_AD[3]  = 8'h06;
    @(posedge clk);
    #1;
    p_in_AD[3] = 8'h3C;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    n_cmp++;
    if (p_ack !== 4'h0) begin n_fail++; $display("FAIL mid_ack0: got %b want 0000", p_ack); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (p_ack !== 4'h0) begin n_fail++; $display("FAIL mid_ack1: got %b want 0000", p_ack); end
    access(1, 1'b1, 8'h04, 8'h11, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL mid_lock4_cleared: got %b want 00", e); end
    access(0, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL mid_reg6: got %h want 00", d); end
    access(2, 1'b1, 8'h06, 8'h77, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (e !== 2'b00) begin n_fail++; $display("FAIL mid_lock6_none: got %b want 00", e); end
    access(1, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, e, d, l);
    n_cmp++;
    if (d !== 8'h11) begin n_fail++; $display("FAIL mid_reg4: got %h want 11", d); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_contention();
    test_lock();
    test_errors();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
